// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory arbiter:
//   - funct3 access-size codes (LS_B, LS_H, LS_W, LS_BU, LS_HU)
//   - IDLE_CODE, the "no access" control code on both memory control buses
//   - state_e, the arbiter sequencing states
//   - access_legal(), the alignment / encoding check on a latched request
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] LS_B      = 3'b000;
    localparam logic [2:0] LS_H      = 3'b001;
    localparam logic [2:0] LS_W      = 3'b010;
    localparam logic [2:0] LS_BU     = 3'b100;
    localparam logic [2:0] LS_HU     = 3'b101;

    localparam logic [2:0] IDLE_CODE = 3'b111;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // 1 when the access may be forwarded to memory. Unsigned sizes are
    // load-only; halfwords need even addresses, words need 4-byte alignment.
    function automatic logic access_legal(input logic [2:0] funct3,
                                          input logic       we,
                                          input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            LS_B:    ok = 1'b1;
            LS_H:    ok = ~addr_lo[0];
            LS_W:    ok = (addr_lo == 2'b00);
            LS_BU:   ok = ~we;
            LS_HU:   ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// -----------------------------------------------------------------------------
// dmem_arb_pick
// Pure combinational winner selection between two requesters.
// Build option: DMEM_ARB_ROUND_ROBIN_EN
//   defined   : on contention the port named by ptr (the one not granted
//               last) wins.
//   undefined : port 0 wins unless the consecutive-grant counter has reached
//               MAX_CONSEC, in which case port 1 wins.
// Ports:
//   req     in  2   request bits, [0] = port 0, [1] = port 1
//   ptr     in  1   preferred port on contention (round-robin build)
//   cnt     in  4   back-to-back port-0 grants while port 1 waited (fixed build)
//   winner  out 1   index of the selected port
//   valid   out 1   at least one request present
// -----------------------------------------------------------------------------
module dmem_arb_pick #(
    parameter logic [3:0] MAX_CONSEC = 4'd4
) (
    input  logic [1:0] req,
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    input  logic       ptr,
`else
    input  logic [3:0] cnt,
`endif
    output logic       winner,
    output logic       valid
);

    // Winner selection; a lone requester always wins.
    always_comb begin
        valid  = req[0] | req[1];
        winner = 1'b0;
        if (req == 2'b11) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            winner = ptr;
`else
            if (cnt == MAX_CONSEC) begin
                winner = 1'b1;
            end else begin
                winner = 1'b0;
            end
`endif
        end else if (req[1]) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter/sequencer in front of the byte-addressable 32-bit data
// memory. Port 0 = core load/store unit, port 1 = debug/program loader.
// A granted request is latched in IDLE, checked and issued to memory in a
// single ACCESS cycle, and answered with a registered rvalid/rdata/err pulse
// on the following cycle. Illegal accesses never drive memory controls.
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of fixed priority with the MAX_CONSEC starvation guard.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pN_req/we/funct3/addr/wdata   request from port N (held until pN_gnt)
//   pN_gnt                   one-cycle combinational grant
//   pN_rvalid/rdata/err      registered response
//   mem_ReadControl/WriteControl/Address/WriteData   memory drive
//   mem_ReadData             combinational read data from memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int         ADDR_W     = 8,
    parameter int         MAX_CONSEC = 4,
    parameter logic [2:0] IDLE_CODE  = dmem_pkg::IDLE_CODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [2:0]        p0_funct3,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [2:0]        p1_funct3,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [31:0]       p0_rdata,
    output logic [31:0]       p1_rdata,
    output logic              p0_err,
    output logic              p1_err,
    output logic [2:0]        mem_ReadControl,
    output logic [2:0]        mem_WriteControl,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [31:0]       mem_WriteData,
    input  logic [31:0]       mem_ReadData
);
    import dmem_pkg::*;

    state_e            state_r;
    state_e            next_state_s;
    logic              grant_s;
    logic              winner_s;
    logic              pick_valid_s;
    logic              legal_s;
    logic [2:0]        rd_ctrl_s;
    logic [2:0]        wr_ctrl_s;
    logic [31:0]       resp_data_s;

    // Latched request
    logic              port_r;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;

    // Registered responses
    logic              p0_rvalid_r;
    logic              p1_rvalid_r;
    logic [31:0]       p0_rdata_r;
    logic [31:0]       p1_rdata_r;
    logic              p0_err_r;
    logic              p1_err_r;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic              ptr_r;

    dmem_arb_pick u_pick (
        .req    ({p1_req, p0_req}),
        .ptr    (ptr_r),
        .winner (winner_s),
        .valid  (pick_valid_s)
    );
`else
    localparam logic [3:0] MAX_CONSEC_C = MAX_CONSEC[3:0];
    logic [3:0]        cnt_r;

    dmem_arb_pick #(
        .MAX_CONSEC (MAX_CONSEC_C)
    ) u_pick (
        .req    ({p1_req, p0_req}),
        .cnt    (cnt_r),
        .winner (winner_s),
        .valid  (pick_valid_s)
    );
`endif

    assign legal_s       = access_legal(funct3_r, we_r, addr_r[1:0]);
    assign resp_data_s   = (legal_s && !we_r) ? mem_ReadData : 32'd0;
    assign mem_Address   = addr_r;
    assign mem_WriteData = wdata_r;
    assign p0_rvalid     = p0_rvalid_r;
    assign p1_rvalid     = p1_rvalid_r;
    assign p0_rdata      = p0_rdata_r;
    assign p1_rdata      = p1_rdata_r;
    assign p0_err        = p0_err_r;
    assign p1_err        = p1_err_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state, grant and memory-control decode
    always_comb begin
        next_state_s = state_r;
        grant_s      = 1'b0;
        rd_ctrl_s    = IDLE_CODE;
        wr_ctrl_s    = IDLE_CODE;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_s      = 1'b1;
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                next_state_s = IDLE;
                if (legal_s && we_r) begin
                    wr_ctrl_s = funct3_r;
                end else if (legal_s) begin
                    rd_ctrl_s = funct3_r;
                end else begin
                    rd_ctrl_s = IDLE_CODE;
                    wr_ctrl_s = IDLE_CODE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Reset overrides grants and memory controls so nothing is written while
    // rst is high, even mid-access.
    always_comb begin
        if (rst) begin
            p0_gnt           = 1'b0;
            p1_gnt           = 1'b0;
            mem_ReadControl  = IDLE_CODE;
            mem_WriteControl = IDLE_CODE;
        end else begin
            p0_gnt           = grant_s & ~winner_s;
            p1_gnt           = grant_s & winner_s;
            mem_ReadControl  = rd_ctrl_s;
            mem_WriteControl = wr_ctrl_s;
        end
    end

    // Capture the winning request's fields at grant
    always_ff @(posedge clk) begin
        if (rst) begin
            port_r   <= 1'b0;
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= '0;
            wdata_r  <= 32'd0;
        end else if (grant_s) begin
            port_r   <= winner_s;
            we_r     <= winner_s ? p1_we     : p0_we;
            funct3_r <= winner_s ? p1_funct3 : p0_funct3;
            addr_r   <= winner_s ? p1_addr   : p0_addr;
            wdata_r  <= winner_s ? p1_wdata  : p0_wdata;
        end
    end

    // Response registers: one rvalid pulse to the owner after ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            p0_rdata_r  <= 32'd0;
            p1_rdata_r  <= 32'd0;
            p0_err_r    <= 1'b0;
            p1_err_r    <= 1'b0;
        end else begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            if (state_r == ACCESS) begin
                if (port_r == 1'b0) begin
                    p0_rvalid_r <= 1'b1;
                    p0_rdata_r  <= resp_data_s;
                    p0_err_r    <= ~legal_s;
                end else begin
                    p1_rvalid_r <= 1'b1;
                    p1_rdata_r  <= resp_data_s;
                    p1_err_r    <= ~legal_s;
                end
            end
        end
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Pointer names the port that did not win the most recent grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (grant_s) begin
            ptr_r <= ~winner_s;
        end
    end
`else
    // Counts port-0 grants taken while port 1 is waiting; any port-1 grant or
    // a quiet port 1 restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (!p1_req || p1_gnt) begin
            cnt_r <= 4'd0;
        end else if (p0_gnt) begin
            cnt_r <= cnt_r + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives dmem_arbiter against a behavioural 256-byte memory. A reference byte
// array and the expected response of every granted request are computed when
// the grant is observed; responses are popped and compared as they arrive.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [2:0]  p0_funct3, p1_funct3;
    logic [7:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [2:0]  mem_ReadControl, mem_WriteControl;
    logic [7:0]  mem_Address;
    logic [31:0] mem_WriteData, mem_ReadData;

    logic [7:0]  mem     [0:255];
    logic [7:0]  ref_mem [0:255];
    exp_t        q0[$];
    exp_t        q1[$];
    int          gnt_log[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          abort_next = 1'b0;
    bit          b2b_mode = 1'b0;
    int          last_gnt0 = -1;

    dmem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .p0_req           (p0_req),
        .p0_we            (p0_we),
        .p0_funct3        (p0_funct3),
        .p0_addr          (p0_addr),
        .p0_wdata         (p0_wdata),
        .p1_req           (p1_req),
        .p1_we            (p1_we),
        .p1_funct3        (p1_funct3),
        .p1_addr          (p1_addr),
        .p1_wdata         (p1_wdata),
        .p0_gnt           (p0_gnt),
        .p1_gnt           (p1_gnt),
        .p0_rvalid        (p0_rvalid),
        .p1_rvalid        (p1_rvalid),
        .p0_rdata         (p0_rdata),
        .p1_rdata         (p1_rdata),
        .p0_err           (p0_err),
        .p1_err           (p1_err),
        .mem_ReadControl  (mem_ReadControl),
        .mem_WriteControl (mem_WriteControl),
        .mem_Address      (mem_Address),
        .mem_WriteData    (mem_WriteData),
        .mem_ReadData     (mem_ReadData)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on each active edge
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b010:  return w;
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_legal(input bit we, input bit [2:0] f3, input bit [7:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
        if (we && f3[2]) return 1'b0;
        if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b0;
        if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    // Behavioural memory: combinational read, write on the clock edge
    always_comb begin
        mem_ReadData = fmt_load(mem_ReadControl,
            {mem[mem_Address + 8'd3], mem[mem_Address + 8'd2],
             mem[mem_Address + 8'd1], mem[mem_Address]});
    end

    always @(posedge clk) begin
        case (mem_WriteControl)
            3'b000: mem[mem_Address] <= mem_WriteData[7:0];
            3'b001: begin
                mem[mem_Address]         <= mem_WriteData[7:0];
                mem[mem_Address + 8'd1]  <= mem_WriteData[15:8];
            end
            3'b010: begin
                mem[mem_Address]         <= mem_WriteData[7:0];
                mem[mem_Address + 8'd1]  <= mem_WriteData[15:8];
                mem[mem_Address + 8'd2]  <= mem_WriteData[23:16];
                mem[mem_Address + 8'd3]  <= mem_WriteData[31:24];
            end
            default: ;
        endcase
    end

    task automatic on_grant(input int port, input bit we, input bit [2:0] f3,
                            input bit [7:0] a, input bit [31:0] wd);
        exp_t e;
        bit   ok;
        if (abort_next) begin
            abort_next = 1'b0;
        end else begin
            ok      = ref_legal(we, f3, a);
            e.err   = ~ok;
            e.cyc   = cyc + 2;
            e.rdata = (ok && !we) ? fmt_load(f3, {ref_mem[a + 8'd3], ref_mem[a + 8'd2],
                                                  ref_mem[a + 8'd1], ref_mem[a]}) : 32'd0;
            if (ok && we) begin
                ref_mem[a] = wd[7:0];
                if (f3 != 3'b000) ref_mem[a + 8'd1] = wd[15:8];
                if (f3 == 3'b010) begin
                    ref_mem[a + 8'd2] = wd[23:16];
                    ref_mem[a + 8'd3] = wd[31:24];
                end
            end
            if (port == 0) q0.push_back(e);
            else           q1.push_back(e);
            gnt_log.push_back(port);
            if (b2b_mode && port == 0) begin
                if (last_gnt0 >= 0) check_eq("b2b gnt spacing", cyc - last_gnt0, 2);
                last_gnt0 = cyc;
            end
        end
    endtask

    task automatic on_resp(input int port, input logic vld, input logic [31:0] rd, input logic er);
        exp_t e;
        bit   empty;
        empty = (port == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
            check_eq($sformatf("p%0d unexpected rvalid", port), {31'd0, vld}, 32'd0);
        end else begin
            if (port == 0) e = q0.pop_front();
            else           e = q1.pop_front();
            check_eq($sformatf("p%0d rdata", port), rd, e.rdata);
            check_eq($sformatf("p%0d err", port), {31'd0, er}, {31'd0, e.err});
            check_eq($sformatf("p%0d latency", port), cyc, e.cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (p0_rvalid) on_resp(0, p0_rvalid, p0_rdata, p0_err);
        if (p1_rvalid) on_resp(1, p1_rvalid, p1_rdata, p1_err);
        if (p0_gnt) on_grant(0, p0_we, p0_funct3, p0_addr, p0_wdata);
        if (p1_gnt) on_grant(1, p1_we, p1_funct3, p1_addr, p1_wdata);
    end

    // Raise a request, hold it until granted, then drop it during ACCESS.
    // Entered and left one time unit after a rising edge.
    task automatic do_req(input int port, input bit we, input bit [2:0] f3,
                          input bit [7:0] a, input bit [31:0] wd);
        bit seen = 1'b0;
        if (port == 0) begin
            p0_req = 1'b1; p0_we = we; p0_funct3 = f3; p0_addr = a; p0_wdata = wd;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_funct3 = f3; p1_addr = a; p1_wdata = wd;
        end
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (port == 0) ? p0_gnt : p1_gnt;
        end
        check_eq($sformatf("p%0d gnt before timeout", port), {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    task automatic check_ctrl_idle(input string tag);
        check_eq({tag, " ReadControl"},  {29'd0, mem_ReadControl},  32'd7);
        check_eq({tag, " WriteControl"}, {29'd0, mem_WriteControl}, 32'd7);
    endtask

    initial begin
        int base;
        int exp_seq [6];
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        p1_req = 1'b0; p1_we = 1'b0; p1_funct3 = 3'b000; p1_addr = 8'h00; p1_wdata = 32'd0;
        // A store held high during reset must be neither granted nor written
        p0_req = 1'b1; p0_we = 1'b1; p0_funct3 = 3'b010; p0_addr = 8'h08; p0_wdata = 32'hCAFEF00D;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset p0_gnt",    {31'd0, p0_gnt},    32'd0);
        check_eq("reset p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
        check_eq("reset p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
        check_eq("reset p0_err",    {31'd0, p0_err},    32'd0);
        check_eq("reset p0_rdata",  p0_rdata,           32'd0);
        check_ctrl_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0; p0_req = 1'b0;

        // Port 0: word store then loads of various sizes
        do_req(0, 1'b1, 3'b010, 8'h08, 32'hDEADBEEF);
        do_req(0, 1'b0, 3'b010, 8'h08, 32'd0);
        do_req(0, 1'b0, 3'b000, 8'h0B, 32'd0);
        do_req(0, 1'b0, 3'b100, 8'h0B, 32'd0);

        // Port 1: misaligned halfword load never reaches memory
        do_req(1, 1'b0, 3'b001, 8'h05, 32'd0);
        @(negedge clk);
        check_ctrl_idle("misaligned lh");
        @(posedge clk); #1;
        // Unsigned-size store is illegal and leaves memory untouched
        do_req(1, 1'b1, 3'b100, 8'h08, 32'h000000FF);
        do_req(1, 1'b0, 3'b010, 8'h08, 32'd0);
        // Reserved funct3
        do_req(1, 1'b0, 3'b011, 8'h00, 32'd0);
        // Halfword store by port 1, read back unsigned by port 0
        do_req(1, 1'b1, 3'b001, 8'h20, 32'h1234ABCD);
        do_req(0, 1'b0, 3'b101, 8'h20, 32'd0);
        do_req(1, 1'b0, 3'b010, 8'h0C, 32'd0);

        // Contention: both requests held through six grants
        base = gnt_log.size();
        p0_req = 1'b1; p0_we = 1'b0; p0_funct3 = 3'b010; p0_addr = 8'h08;
        p1_req = 1'b1; p1_we = 1'b0; p1_funct3 = 3'b010; p1_addr = 8'h0C;
        for (int i = 0; i < 40 && gnt_log.size() < base + 6; i++) @(negedge clk);
        @(posedge clk); #1;
        p0_req = 1'b0; p1_req = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0, 1, 0};
`endif
        check_eq("contention grant count", gnt_log.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < gnt_log.size())
                check_eq($sformatf("grant order %0d", i), gnt_log[base + i], exp_seq[i]);
        end
        repeat (3) @(posedge clk); #1;

        // Back-to-back port-0 loads: one grant every second cycle
        b2b_mode = 1'b1; last_gnt0 = -1;
        do_req(0, 1'b0, 3'b010, 8'h08, 32'd0);
        do_req(0, 1'b0, 3'b100, 8'h08, 32'd0);
        do_req(0, 1'b0, 3'b001, 8'h0A, 32'd0);
        do_req(0, 1'b0, 3'b101, 8'h08, 32'd0);
        b2b_mode = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset during the ACCESS cycle of a store aborts it with no response
        abort_next = 1'b1;
        do_req(0, 1'b1, 3'b010, 8'h10, 32'h12345678);
        rst = 1'b1;
        @(negedge clk);
        check_ctrl_idle("rst in ACCESS");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("p0_rdata after rst", p0_rdata, 32'd0);
        @(posedge clk); #1;
        do_req(0, 1'b0, 3'b010, 8'h10, 32'd0);

        // Drain outstanding responses
        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        check_eq("p0 queue drained", q0.size(), 0);
        check_eq("p1 queue drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
